// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl: sequencer for a rate-1/2 hard-decision Viterbi datapath.
// Accepts one received symbol per IDLE handshake, steps the ACS unit once,
// advances the circular survivor write pointer and, once WIN_DEPTH columns
// are held, walks a full-depth traceback and offers one decoded bit.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   clr             synchronous soft clear, same effect as reset
//   sym_valid/ready received-symbol handshake
//   acs_en          one ACS step, survivor column wr_addr written
//   wr_addr         survivor write column
//   init_phase      trellis start-up (first K-1 symbols)
//   pm_all_msb      all path metrics have MSB set
//   pm_norm         metric normalisation during this ACS step
//   tb_rd_en        traceback read of column tb_addr
//   tb_addr         traceback column
//   tb_bit          decision bit read from tb_addr
//   dec_valid/ready decoded-bit handshake, dec_bit carries the bit
module viterbi_ctrl #(
  parameter int unsigned WIN_DEPTH = 15,
  parameter int unsigned K         = 3,
  parameter int unsigned AW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          sym_valid,
  output logic          sym_ready,
  output logic          acs_en,
  output logic [AW-1:0] wr_addr,
  output logic          init_phase,
  input  logic          pm_all_msb,
  output logic          pm_norm,
  output logic          tb_rd_en,
  output logic [AW-1:0] tb_addr,
  input  logic          tb_bit,
  output logic          dec_valid,
  output logic          dec_bit,
  input  logic          dec_ready
);

  localparam int unsigned CW = $clog2(WIN_DEPTH + 1);
  localparam logic [AW-1:0] LAST_COL = AW'(WIN_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIN_DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, ACS, TRACE, EMIT} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   tb_addr_q, tb_addr_d;
  logic [AW-1:0]   tcnt_q, tcnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dec_bit_q, dec_bit_d;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    tb_addr_d = tb_addr_q;
    tcnt_d    = tcnt_q;
    cnt_d     = cnt_q;
    dec_bit_d = dec_bit_q;
    unique case (state_q)
      IDLE: begin
        if (sym_valid) state_d = ACS;
      end
      ACS: begin
        wptr_d = (wptr_q == LAST_COL) ? '0 : wptr_q + AW'(1);
        cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
        if (cnt_d == CNT_FULL) begin
          // the column just written is the traceback start point
          state_d   = TRACE;
          tb_addr_d = wptr_q;
          tcnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      TRACE: begin
        if (tcnt_q == LAST_COL) begin
          // oldest column reached: its decision is the decoded bit
          dec_bit_d = tb_bit;
          state_d   = EMIT;
        end else begin
          tcnt_d    = tcnt_q + AW'(1);
          tb_addr_d = (tb_addr_q == '0) ? LAST_COL : tb_addr_q - AW'(1);
        end
      end
      EMIT: begin
        if (dec_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      tb_addr_q <= '0;
      tcnt_q    <= '0;
      cnt_q     <= '0;
      dec_bit_q <= 1'b0;
    end else if (clr) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      tb_addr_q <= '0;
      tcnt_q    <= '0;
      cnt_q     <= '0;
      dec_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      tb_addr_q <= tb_addr_d;
      tcnt_q    <= tcnt_d;
      cnt_q     <= cnt_d;
      dec_bit_q <= dec_bit_d;
    end
  end

  assign sym_ready  = (state_q == IDLE);
  assign acs_en     = (state_q == ACS);
  assign tb_rd_en   = (state_q == TRACE);
  assign dec_valid  = (state_q == EMIT);
  assign init_phase = acs_en && (cnt_q < CNT_INIT);
  // normalisation only applies to the metrics being updated in this step
  assign pm_norm    = acs_en && pm_all_msb;
  assign wr_addr    = wptr_q;
  assign tb_addr    = tb_addr_q;
  assign dec_bit    = dec_bit_q;

endmodule

// File: doc/viterbi_ctrl.md
Name: viterbi_ctrl

Overview:
- Sequencer for the K=3..6, rate-1/2 hard-decision Viterbi datapath (branch metric, ACS and survivor memory of WIN_DEPTH columns).
- Accepts received 2-bit symbols over a valid/ready handshake.
- Steps the ACS unit once per symbol and manages the circular survivor-memory write pointer.
- Once the window is full, runs a full-depth traceback per symbol and emits one decoded bit over a valid/ready handshake.

Parameters:
- WIN_DEPTH, 15, survivor window depth and traceback length in columns (2..16).
- K, 3, constraint length (3..6); sets the trellis start-up length K-1.
- AW, 4, survivor column address width; must satisfy 2^AW >= WIN_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active low.
- clr  in  1  synchronous soft clear; same effect as reset, one cycle.
- sym_valid  in  1  a received symbol is available.
- sym_ready  out  1  controller accepts a symbol this cycle.
- acs_en  out  1  datapath performs one ACS step and writes survivor column wr_addr.
- wr_addr  out  AW  survivor column written when acs_en=1.
- init_phase  out  1  trellis start-up; the datapath restricts reachable states.
- pm_all_msb  in  1  all state path metrics have their MSB set.
- pm_norm  out  1  datapath subtracts 2^(PM_W-1) from every metric during this ACS step.
- tb_rd_en  out  1  survivor column tb_addr is being read for traceback.
- tb_addr  out  AW  traceback column.
- tb_bit  in  1  decision bit from column tb_addr; combinational, valid while tb_rd_en=1.
- dec_valid  out  1  decoded bit available.
- dec_bit  out  1  decoded bit.
- dec_ready  in  1  downstream consumes dec_bit.

Behaviour:
- Reset (rst_n=0 or clr=1):
  - state=IDLE; wptr=0; sym_cnt=0.
  - acs_en, pm_norm, tb_rd_en, dec_valid, dec_bit, init_phase all 0; wr_addr=0; tb_addr=0.
  - sym_ready=1 once reset is released.
  - Reset mid-traceback or mid-EMIT discards all work in flight; no dec_valid is produced.
  - clr has priority over every other event in the same cycle.
- FSM states: IDLE, ACS, TRACE, EMIT. All outputs are registered or decoded from state only.
- IDLE:
  - sym_ready=1 (no other state drives it high).
  - sym_valid=1 moves the FSM to ACS next cycle. The datapath latches the symbol on the same handshake edge.
- ACS (exactly 1 cycle):
  - acs_en=1; wr_addr=wptr.
  - init_phase=1 iff sym_cnt < K-1.
  - pm_norm=pm_all_msb, sampled this cycle.
  - At the end of the cycle: wptr increments modulo WIN_DEPTH (WIN_DEPTH-1 wraps to 0), and sym_cnt increments, saturating at WIN_DEPTH.
  - Next state: TRACE if the new sym_cnt == WIN_DEPTH, else IDLE.
- TRACE (exactly WIN_DEPTH cycles):
  - tb_rd_en=1 throughout.
  - First cycle: tb_addr = last written column (wptr-1 mod WIN_DEPTH).
  - tb_addr then decrements modulo WIN_DEPTH each cycle (0 wraps to WIN_DEPTH-1).
  - The last cycle reads the oldest column (== wptr); tb_bit is registered into dec_bit on that cycle.
  - Next state: EMIT.
- EMIT:
  - dec_valid=1 and dec_bit holds until dec_ready=1.
  - On the handshake cycle the FSM returns to IDLE; dec_valid drops the next cycle.
  - dec_ready while dec_valid=0 is ignored.
- Throughput and latency:
  - Before the window fills: one symbol per 2 cycles.
  - Steady state: one symbol per WIN_DEPTH+3 cycles when dec_ready is tied high.
  - Latency: dec_valid rises WIN_DEPTH+1 cycles after the ACS cycle of the symbol that filled or refreshed the window.
- Saturation: sym_cnt stays at WIN_DEPTH once reached; every later symbol triggers a traceback.
- Backpressure: sym_valid held high in ACS, TRACE or EMIT is not accepted; the symbol must persist until sym_ready=1.

Test Plan:
- Reset then 3 back-to-back symbols (WIN_DEPTH=15, K=3) -> acs_en pulses on cycles 2, 4, 6 after first valid; wr_addr 0,1,2; init_phase 1,1,0; no tb_rd_en.
- Feed 15 symbols -> after 15th ACS, tb_rd_en high 15 cycles with tb_addr 14,13,...,0. Force tb_bit=1 only at tb_addr=0 -> dec_valid with dec_bit=1.
- Feed a 16th symbol with dec_ready=1 -> wr_addr=0 (wrap); traceback tb_addr 0,14,13,...,1; one decoded bit; inter-symbol period 18 cycles.
- dec_ready held low 5 cycles in EMIT -> dec_valid and dec_bit stable, sym_ready=0 throughout; dec_ready=1 -> IDLE, sym_ready=1 next cycle.
- pm_all_msb=1 during one ACS cycle and 1 in an IDLE cycle -> pm_norm=1 only in the ACS cycle.
- rst_n low at TRACE cycle 7, and separately clr=1 in EMIT -> all outputs reset values, wptr=0, no dec_valid; next symbol writes wr_addr=0 with init_phase=1.
